// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for a bank of common-anode 7-segment digits.
// Latency: nibble/digit_sel/frame_tick are registered one cycle behind digit_idx/disp;
//          a loaded value reaches the display at the next frame boundary.
// Backpressure: none; load is always accepted (last load before a frame end wins).
// Build option: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always lit).
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,     // digits scanned, 2..8
  parameter int SCAN_DIV   = 50000  // clk cycles per digit slot, >= 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      display_en,
  output logic [3:0]                nibble,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      pending,
  output logic                      frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

  // Scan timing state
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [IW-1:0] digit_idx_q, digit_idx_d;
  logic          slot_end;
  logic          frame_end;

  // Double buffer: shadow collects loads, disp is what the scan shows
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    pending_q, pending_d;

  // Registered outputs
  logic [3:0]            nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic                  frame_tick_q;

  // Per-digit blank flags for the displayed value
  logic [NUM_DIGITS-1:0] blank;

  assign slot_end  = (prescaler_q == PRESC_LAST);
  assign frame_end = slot_end && (digit_idx_q == DIGIT_LAST);

  // Next prescaler and digit index; the index wraps explicitly so non-power-of-2 counts work
  always_comb begin
    prescaler_d = prescaler_q;
    digit_idx_d = digit_idx_q;
    if (slot_end) begin
      prescaler_d = '0;
      if (digit_idx_q == DIGIT_LAST) begin
        digit_idx_d = '0;
      end else begin
        digit_idx_d = digit_idx_q + 1'b1;
      end
    end else begin
      prescaler_d = prescaler_q + 1'b1;
    end
  end

  // Scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q <= '0;
      digit_idx_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  // Load into shadow; commit to disp only on a frame end so a frame never mixes two values.
  // A load landing on the frame-end cycle bypasses the shadow and commits straight away.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        disp_d    = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Double-buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k>0 is blank when it and every digit above it hold zero
  logic lz_run;
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_run   = lz_run && (disp_q[4*k +: 4] == 4'h0);
      blank[k] = lz_run;
    end
  end
`else
  // Blanking disabled: every digit is lit, leading zeros included
  assign blank = '0;
`endif

  // Select current nibble and the one-hot active-low anode for the current slot
  always_comb begin
    nibble_d    = 4'h0;
    digit_sel_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx_q == IW'(k)) begin
        nibble_d = disp_q[4*k +: 4];
        if (display_en && !blank[k]) begin
          digit_sel_d[k] = 1'b0;
        end
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble_q     <= 4'h0;
      digit_sel_q  <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      nibble_q     <= nibble_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_end;
    end
  end

  assign nibble     = nibble_q;
  assign digit_sel  = digit_sel_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule
